// File: rtl/sdram_cmd_sequencer.sv
// sdram_cmd_sequencer
//   Timing FSM in front of the SDRAM command decoder. After reset it runs the
//   power-up sequence (NOP wait, PALL, two REFs, MRS). It then serves
//   single-beat read/write accesses using auto-precharge, and interleaves
//   periodic auto-refresh. Every output is a flop, so the decoder sees one
//   4-bit command per cycle. NOP is driven whenever no command is issued.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; restarts the full init sequence
//   req_valid  access request
//   req_we     1 = write, 0 = read (captured on accept)
//   req_addr   {bank[21:20], col[19:10], row[9:0]} (captured on accept)
//   req_ready  request can be accepted this cycle
//   command    NOP 0001, MRS 0010, ACT 0011, READA 0101, WRITA 0111,
//              PALL 1001, REF 1011
//   addr_out   latched request address
//   mrs        constant mode register value
//   init_done  init sequence complete, sticky until reset
//   wr_strobe  one-cycle pulse in the WRITA cycle
//   rd_valid   one-cycle pulse CAS_LAT cycles after the READA cycle
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is only high in IDLE after init, and only
// while no refresh is pending. The requester keeps req_valid (and its
// we/addr) stable until the transfer happens.
module sdram_cmd_sequencer #(
    parameter int          T_INIT     = 10000,
    parameter int          T_RP       = 2,
    parameter int          T_RCD      = 2,
    parameter int          T_RFC      = 7,
    parameter int          T_MRD      = 2,
    parameter int          T_WR       = 2,
    parameter int          CAS_LAT    = 2,
    parameter int          REF_PERIOD = 780,
    parameter logic [11:0] MRS_VAL    = 12'h022
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [21:0] req_addr,
    output logic        req_ready,
    output logic [3:0]  command,
    output logic [21:0] addr_out,
    output logic [11:0] mrs,
    output logic        init_done,
    output logic        wr_strobe,
    output logic        rd_valid
);

    localparam int MAX_T = (T_INIT > REF_PERIOD) ? T_INIT : REF_PERIOD;
    localparam int CNT_W = $clog2(MAX_T + 1);

    localparam logic [3:0] CMD_NOP   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0010;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READA = 4'b0101;
    localparam logic [3:0] CMD_WRITA = 4'b0111;
    localparam logic [3:0] CMD_PALL  = 4'b1001;
    localparam logic [3:0] CMD_REF   = 4'b1011;

    // Each load value is "cycles until the next command" minus one. The
    // counter is loaded on the edge that issues a command, and the next
    // command goes out on the edge where it is already zero.
    localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(T_INIT - 1);
    localparam logic [CNT_W-1:0] LD_RP   = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RFC  = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] LD_MRD  = CNT_W'(T_MRD - 1);
    localparam logic [CNT_W-1:0] LD_RCD  = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0] LD_RD   = CNT_W'(CAS_LAT + T_RP - 1);
    localparam logic [CNT_W-1:0] LD_WR   = CNT_W'(T_WR + T_RP - 1);
    localparam logic [CNT_W-1:0] LD_REF  = CNT_W'(REF_PERIOD - 1);

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_PALL,
        S_INIT_REF1,
        S_INIT_REF2,
        S_INIT_MRS,
        S_IDLE,
        S_ACTIVE,
        S_RW,
        S_PRECH,
        S_REFRESH
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [CNT_W-1:0]     ref_cnt;
    logic                 ref_pending, ref_pending_n;
    logic                 ref_expire;
    logic                 issue_ref;
    logic                 accept;
    logic                 we_q;
    logic [3:0]           cmd_n;
    logic                 wr_strobe_n;
    logic                 init_done_n;
    logic                 req_ready_n;
    logic [CAS_LAT-1:0]   rd_sr;

    assign mrs      = MRS_VAL;
    assign rd_valid = rd_sr[CAS_LAT-1];

    // The refresh timer only runs after init. An expiry while a refresh is
    // already pending simply keeps the flag set, so refreshes never queue up.
    assign ref_expire = init_done && (ref_cnt == '0);

    always_comb begin
        state_n     = state;
        cnt_n       = (cnt != '0) ? cnt - 1'b1 : '0;
        cmd_n       = CMD_NOP;
        wr_strobe_n = 1'b0;
        init_done_n = init_done;
        issue_ref   = 1'b0;
        accept      = 1'b0;
        case (state)
            S_INIT_WAIT: if (cnt == '0) begin
                state_n = S_INIT_PALL;
                cmd_n   = CMD_PALL;
                cnt_n   = LD_RP;
            end
            S_INIT_PALL: if (cnt == '0) begin
                state_n = S_INIT_REF1;
                cmd_n   = CMD_REF;
                cnt_n   = LD_RFC;
            end
            S_INIT_REF1: if (cnt == '0) begin
                state_n = S_INIT_REF2;
                cmd_n   = CMD_REF;
                cnt_n   = LD_RFC;
            end
            S_INIT_REF2: if (cnt == '0) begin
                state_n = S_INIT_MRS;
                cmd_n   = CMD_MRS;
                cnt_n   = LD_MRD;
            end
            S_INIT_MRS: if (cnt == '0) begin
                state_n     = S_IDLE;
                init_done_n = 1'b1;
            end
            S_IDLE: begin
                if (ref_pending) begin
                    state_n   = S_REFRESH;
                    cmd_n     = CMD_REF;
                    cnt_n     = LD_RFC;
                    issue_ref = 1'b1;
                end else if (req_valid && req_ready) begin
                    // The accept edge itself is a NOP. ACT follows on the next
                    // edge, which is recognised by the counter still holding
                    // its full T_RCD load.
                    state_n = S_ACTIVE;
                    accept  = 1'b1;
                    cnt_n   = LD_RCD;
                end
            end
            S_ACTIVE: begin
                if (cnt == LD_RCD) begin
                    cmd_n = CMD_ACT;
                end else if (cnt == '0) begin
                    state_n     = S_RW;
                    cmd_n       = we_q ? CMD_WRITA : CMD_READA;
                    wr_strobe_n = we_q;
                    cnt_n       = we_q ? LD_WR : LD_RD;
                end
            end
            // The RW state only holds the READA/WRITA cycle. The rest of the
            // CAS/write-recovery + precharge window runs down in PRECH.
            S_RW:    state_n = S_PRECH;
            S_PRECH: if (cnt == '0) state_n = S_IDLE;
            S_REFRESH: if (cnt == '0) state_n = S_IDLE;
            default: begin
                state_n = S_INIT_WAIT;
                cnt_n   = LD_INIT;
            end
        endcase

        if (ref_expire) begin
            ref_pending_n = 1'b1;
        end else if (issue_ref) begin
            ref_pending_n = 1'b0;
        end else begin
            ref_pending_n = ref_pending;
        end

        req_ready_n = (state_n == S_IDLE) && init_done_n && !ref_pending_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_INIT_WAIT;
            cnt         <= LD_INIT;
            command     <= CMD_NOP;
            addr_out    <= '0;
            we_q        <= 1'b0;
            req_ready   <= 1'b0;
            init_done   <= 1'b0;
            wr_strobe   <= 1'b0;
            rd_sr       <= '0;
            ref_cnt     <= LD_REF;
            ref_pending <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            command     <= cmd_n;
            req_ready   <= req_ready_n;
            init_done   <= init_done_n;
            wr_strobe   <= wr_strobe_n;
            ref_pending <= ref_pending_n;
            if (accept) begin
                addr_out <= req_addr;
                we_q     <= req_we;
            end
            // Delay line from the registered READA to rd_valid.
            rd_sr[0] <= (command == CMD_READA);
            for (int i = 1; i < CAS_LAT; i++) begin
                rd_sr[i] <= rd_sr[i-1];
            end
            if (!init_done || ref_cnt == '0) begin
                ref_cnt <= LD_REF;
            end else begin
                ref_cnt <= ref_cnt - 1'b1;
            end
        end
    end

endmodule
